fsm_counter_param: RTL and testbench

Parametrised up/down counter with an explicit control state machine. It generalises the 3-bit enable-only FSM counter with:
- configurable width and bounds
- four run modes (wrap, saturate, one-shot, bounce)
- synchronous load and clear
- a cascadable terminal-count flag

It sits in the same counter/timer layer and is the drop-in counter for sequencing and timeout logic.

---
 rtl/fsm_counter_pkg.sv | 30 +++
 rtl/fsm_counter_param.sv | 131 +++++++++++++
 tb/tb_fsm_counter_param.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_counter_pkg.sv
// Shared definitions for fsm_counter_param.
//   state_t      : control FSM states (IDLE, RUN, HALT)
//   MODE_*       : run-mode encodings driven on the mode input
//   clamp()      : saturates a value into [lo, hi]; used to bound load values
package fsm_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_BOUNCE  = 2'b11;

    function automatic int unsigned clamp(input int unsigned v,
                                          input int unsigned lo,
                                          input int unsigned hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fsm_counter_param.sv
// Parametrised up/down counter with a small control FSM (IDLE/RUN/HALT).
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   en        in   count enable
//   up        in   requested direction (1 = increment)
//   mode      in   00 wrap, 01 saturate, 10 one-shot, 11 bounce
//   load      in   synchronous load of load_val (clamped to [MIN, MAX])
//   load_val  in   load value
//   clear     in   synchronous return to the post-reset state
//   num       out  registered count
//   tc        out  terminal count, combinational (cascade into a following en)
//   dir       out  effective direction
//   busy      out  state is RUN
//   done      out  state is HALT
module fsm_counter_param
    import fsm_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MIN   = 0,
    parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] num,
    output logic             tc,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic             dir_q, dir_d;

    logic             dir_eff;
    logic [WIDTH-1:0] term;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;

    // Bounce keeps its own direction; all other modes follow up directly.
    assign dir_eff = (mode == MODE_BOUNCE) ? dir_q : up;
    assign term    = dir_eff ? MAX_V : MIN_V;
    assign at_term = (num_q == term);

    assign load_clamped = WIDTH'(clamp(32'(load_val), MIN, MAX));

    // HALT ignores en, so it must also suppress tc to keep cascades quiet.
    assign tc   = en && (state_q != HALT) && at_term;
    assign dir  = dir_eff;
    assign num  = num_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == HALT);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        // Outside bounce dir_q shadows up, so entering bounce starts from the last up.
        dir_d   = (mode == MODE_BOUNCE) ? dir_q : up;

        if (clear) begin
            state_d = IDLE;
            num_d   = MIN_V;
            dir_d   = 1'b1;
        end else if (load) begin
            state_d = RUN;
            num_d   = load_clamped;
            dir_d   = up;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (en) begin
                        state_d = RUN;
                        if (!at_term) begin
                            // Off-terminal step never crosses a bound, so no carry.
                            num_d = dir_eff ? (num_q + ONE_V) : (num_q - ONE_V);
                        end else begin
                            case (mode)
                                MODE_WRAP: begin
                                    num_d = dir_eff ? MIN_V : MAX_V;
                                end
                                MODE_SAT: begin
                                    num_d = num_q;
                                end
                                MODE_ONESHOT: begin
                                    state_d = HALT;
                                end
                                MODE_BOUNCE: begin
                                    dir_d = ~dir_q;
                                    num_d = dir_eff ? (num_q - ONE_V) : (num_q + ONE_V);
                                end
                                default: begin
                                    num_d = num_q;
                                end
                            endcase
                        end
                    end
                end
                HALT: begin
                    num_d = num_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            num_q   <= MIN_V;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_fsm_counter_param.sv
// Bench for fsm_counter_param: two instances (defaults, and WIDTH=4/MIN=2/MAX=5)
// share control inputs; a behavioural model is compared every cycle, plus
// hand-computed directed expectations, then randomized stimulus.
module tb_fsm_counter_param;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic       up    = 1'b0;
    logic       load  = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [2:0] lv0   = 3'd0;
    logic [3:0] lv1   = 4'd0;

    logic [2:0] num0;
    logic [3:0] num1;
    logic       tc0, tc1, dir0, dir1, busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    fsm_counter_param dut0 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .load     (load),
        .load_val (lv0),
        .clear    (clear),
        .num      (num0),
        .tc       (tc0),
        .dir      (dir0),
        .busy     (busy0),
        .done     (done0)
    );

    fsm_counter_param #(
        .WIDTH (4),
        .MIN   (2),
        .MAX   (5)
    ) dut1 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .load     (load),
        .load_val (lv1),
        .clear    (clear),
        .num      (num1),
        .tc       (tc1),
        .dir      (dir1),
        .busy     (busy1),
        .done     (done1)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_on      = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // state: 0 idle, 1 run, 2 halt
    int m_num[2];
    int m_st[2];
    bit m_dq[2];
    int lo[2] = '{0, 2};
    int hi[2] = '{7, 5};

    function automatic bit m_dir(input int i);
        return (mode == 2'b11) ? m_dq[i] : up;
    endfunction

    function automatic bit m_tc(input int i);
        int t;
        t = m_dir(i) ? hi[i] : lo[i];
        return en && (m_st[i] != 2) && (m_num[i] == t);
    endfunction

    task automatic m_step(input int i);
        int lv, d, span, nxt;
        bit ndq;
        lv = (i == 0) ? int'(lv0) : int'(lv1);
        if (clear) begin
            m_num[i] = lo[i];
            m_st[i]  = 0;
            m_dq[i]  = 1'b1;
        end else if (load) begin
            m_num[i] = (lv < lo[i]) ? lo[i] : ((lv > hi[i]) ? hi[i] : lv);
            m_st[i]  = 1;
            m_dq[i]  = up;
        end else begin
            d    = m_dir(i) ? 1 : -1;
            ndq  = (mode == 2'b11) ? m_dq[i] : up;
            span = hi[i] - lo[i] + 1;
            nxt  = m_num[i] + d;
            if (en && m_st[i] != 2) begin
                m_st[i] = 1;
                case (mode)
                    2'b00: m_num[i] = lo[i] + ((m_num[i] - lo[i] + d + span) % span);
                    2'b01: m_num[i] = (nxt < lo[i]) ? lo[i] : ((nxt > hi[i]) ? hi[i] : nxt);
                    2'b10: begin
                        if (nxt < lo[i] || nxt > hi[i]) m_st[i] = 2;
                        else m_num[i] = nxt;
                    end
                    default: begin
                        if (nxt < lo[i] || nxt > hi[i]) begin
                            ndq      = ~m_dq[i];
                            m_num[i] = m_num[i] - d;
                        end else begin
                            m_num[i] = nxt;
                        end
                    end
                endcase
            end
            m_dq[i] = ndq;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_num[i] = lo[i];
                m_st[i]  = 0;
                m_dq[i]  = 1'b1;
            end
        end else begin
            for (int i = 0; i < 2; i++) m_step(i);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("num0",  32'(num0),  32'(m_num[0]));
            chk("tc0",   32'(tc0),   32'(m_tc(0)));
            chk("dir0",  32'(dir0),  32'(m_dir(0)));
            chk("busy0", 32'(busy0), 32'(m_st[0] == 1));
            chk("done0", 32'(done0), 32'(m_st[0] == 2));
            chk("num1",  32'(num1),  32'(m_num[1]));
            chk("tc1",   32'(tc1),   32'(m_tc(1)));
            chk("dir1",  32'(dir1),  32'(m_dir(1)));
            chk("busy1", 32'(busy1), 32'(m_st[1] == 1));
            chk("done1", 32'(done1), 32'(m_st[1] == 2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int sat_seq[4]    = '{1, 0, 0, 0};
    int bnc_seq[5]    = '{5, 4, 3, 2, 3};
    int bnc_dir[5]    = '{1, 0, 0, 0, 1};

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        cmp_on = 1'b1;

        // Reset state
        chk("rst_num0", 32'(num0), 0);
        chk("rst_num1", 32'(num1), 2);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_tc_en0", 32'(tc0), 0);
        mode = 2'b11;
        #1 chk("rst_dirq", 32'(dir0), 1);
        mode = 2'b00;

        // Wrap, counting up from reset
        up = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            chk("wrap_tc", 32'(tc0), 32'(((k - 1) % 8) == 7));
            tick();
            chk("wrap_num", 32'(num0), 32'(k % 8));
            chk("wrap_model", 32'(m_num[0]), 32'(k % 8));
            chk("wrap_busy", 32'(busy0), 1);
        end

        // Saturate down from a load of 2
        en   = 1'b0;
        mode = 2'b01;
        up   = 1'b0;
        lv0  = 3'd2;
        lv1  = 4'd3;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("sat_load", 32'(num0), 2);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sat_num", 32'(num0), 32'(sat_seq[k]));
        end
        chk("sat_tc", 32'(tc0), 1);
        chk("sat_busy", 32'(busy0), 1);
        up = 1'b1;
        tick();
        chk("sat_rev1", 32'(num0), 1);
        tick();
        chk("sat_rev2", 32'(num0), 2);

        // One-shot from 5 up to halt
        en   = 1'b0;
        mode = 2'b10;
        lv0  = 3'd5;
        lv1  = 4'd4;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("os_load", 32'(num0), 5);
        en = 1'b1;
        tick();
        chk("os_6", 32'(num0), 6);
        tick();
        chk("os_7", 32'(num0), 7);
        chk("os_tc_pre", 32'(tc0), 1);
        tick();
        chk("os_hold", 32'(num0), 7);
        chk("os_done", 32'(done0), 1);
        chk("os_busy", 32'(busy0), 0);
        chk("os_tc_halt", 32'(tc0), 0);
        tick();
        chk("os_stay", 32'(num0), 7);
        lv0  = 3'd3;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("os_reload", 32'(num0), 3);
        chk("os_rerun", 32'(busy0), 1);
        chk("os_undone", 32'(done0), 0);

        // Bounce on the MIN=2/MAX=5 instance; up dropped to show dir_q rules
        en   = 1'b0;
        mode = 2'b11;
        up   = 1'b1;
        lv0  = 3'd4;
        lv1  = 4'd4;
        load = 1'b1;
        tick();
        load = 1'b0;
        up   = 1'b0;
        chk("bnc_load", 32'(num1), 4);
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bnc_num", 32'(num1), 32'(bnc_seq[k]));
            chk("bnc_dir", 32'(dir1), 32'(bnc_dir[k]));
        end

        // Priority and clamping
        lv1   = 4'd9;
        load  = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("pri_num0", 32'(num0), 0);
        chk("pri_num1", 32'(num1), 2);
        chk("pri_busy", 32'(busy0), 0);
        chk("pri_done", 32'(done1), 0);
        tick();
        chk("clamp_hi", 32'(num1), 5);
        lv1 = 4'd0;
        tick();
        load = 1'b0;
        chk("clamp_lo", 32'(num1), 2);

        // Async reset between edges
        mode = 2'b00;
        up   = 1'b1;
        en   = 1'b1;
        tick();
        tick();
        tick();
        #1 reset = 1'b1;
        #1;
        chk("arst_num0", 32'(num0), 0);
        chk("arst_num1", 32'(num1), 2);
        chk("arst_busy", 32'(busy0), 0);
        tick();
        reset = 1'b0;
        chk("arst_hold", 32'(num0), 0);
        tick();
        chk("arst_restart", 32'(num0), 1);
        chk("arst_busy2", 32'(busy0), 1);

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            load  = ($urandom_range(0, 19) == 0);
            clear = ($urandom_range(0, 49) == 0);
            lv0   = 3'($urandom_range(0, 7));
            lv1   = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
